// File: rtl/cast_xbar_pkg.sv
// Shared types and helpers for the multicast fork crossbar.
package cast_xbar_pkg;

  localparam int NPORT_DEF = 5;
  localparam int NPORT_MAX = 16;
  localparam int DW_DEF    = 32;

  typedef logic [NPORT_DEF-1:0] port_mask_t;

  // Isolates the lowest set bit: lowest requester index wins.
  function automatic logic [NPORT_MAX-1:0] onehot_lowest(input logic [NPORT_MAX-1:0] req);
    return req & (-req);
  endfunction

endpackage

// File: rtl/xbar_out_slice.sv
// Two-entry valid/ready skid buffer placed on each crossbar output
// when CAST_XBAR_OUT_REG_EN is defined.
module xbar_out_slice #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  // in_ready depends only on occupancy, so the upstream retire path never sees out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/cast_xbar_fork.sv
// N-port multicast crossbar: each flit forks to its target outputs independently and
// retires once all have taken it. Define CAST_XBAR_OUT_REG_EN for registered outputs.
module cast_xbar_fork
  import cast_xbar_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT*NPORT-1:0] sel_in,
  input  logic [NPORT*DW-1:0]    data_in,
  input  logic [NPORT-1:0]       valid_in,
  output logic [NPORT-1:0]       ready_out,
  output logic [NPORT*DW-1:0]    data_out,
  output logic [NPORT-1:0]       valid_out,
  input  logic [NPORT-1:0]       ready_in,
  output logic                   err_drop,
  output logic                   err_conflict
);

  logic [NPORT-1:0]    done    [NPORT];
  logic [NPORT-1:0]    pend    [NPORT];
  logic [NPORT-1:0]    acc     [NPORT];
  logic [NPORT-1:0]    col_req [NPORT];
  logic [NPORT-1:0]    grant   [NPORT];
  logic [NPORT*DW-1:0] mux_data;
  logic [NPORT-1:0]    mux_valid;
  logic [NPORT-1:0]    take;
  logic                drop_now;
  logic                conflict_now;

  always_comb begin
    logic [NPORT_MAX-1:0] req_ext;
    req_ext      = '0;
    mux_data     = '0;
    mux_valid    = '0;
    ready_out    = '0;
    drop_now     = 1'b0;
    conflict_now = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      pend[i] = valid_in[i] ? (sel_in[i*NPORT +: NPORT] & ~done[i]) : '0;
      acc[i]  = '0;
    end
    // Transpose to per-output request columns, then priority-pick per output.
    for (int j = 0; j < NPORT; j++) begin
      col_req[j] = '0;
      for (int i = 0; i < NPORT; i++) col_req[j][i] = pend[i][j];
      req_ext            = '0;
      req_ext[NPORT-1:0] = col_req[j];
      req_ext            = onehot_lowest(req_ext);
      grant[j]           = req_ext[NPORT-1:0];
      mux_valid[j]       = |col_req[j];
      conflict_now       = conflict_now | (col_req[j] != grant[j]);
      for (int i = 0; i < NPORT; i++)
        if (grant[j][i]) mux_data[j*DW +: DW] = data_in[i*DW +: DW];
    end
    for (int i = 0; i < NPORT; i++) begin
      for (int j = 0; j < NPORT; j++) acc[i][j] = grant[j][i] & take[j];
      ready_out[i] = valid_in[i] & ((pend[i] & ~acc[i]) == '0);
      drop_now     = drop_now | (valid_in[i] & (sel_in[i*NPORT +: NPORT] == '0));
    end
  end

`ifdef CAST_XBAR_OUT_REG_EN
  for (genvar j = 0; j < NPORT; j++) begin : g_slice
    xbar_out_slice #(.DW(DW)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (mux_valid[j]),
      .in_ready  (take[j]),
      .in_data   (mux_data[j*DW +: DW]),
      .out_valid (valid_out[j]),
      .out_ready (ready_in[j]),
      .out_data  (data_out[j*DW +: DW])
    );
  end
`else
  assign take      = ready_in;
  assign valid_out = mux_valid;
  assign data_out  = mux_data;
`endif

  // done persists across a dropped valid so an aborted fork resumes on the next flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPORT; i++) done[i] <= '0;
      err_drop     <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (ready_out[i]) done[i] <= '0;
        else              done[i] <= done[i] | acc[i];
      end
      if (drop_now)     err_drop     <= 1'b1;
      if (conflict_now) err_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cast_xbar_fork.sv
// Randomized and directed bench for cast_xbar_fork (combinational-output build).
module tb_cast_xbar_fork;

  localparam int N  = 5;
  localparam int DW = 8;

  logic             clk;
  logic             rst;
  logic [N*N-1:0]   sel_in;
  logic [N*DW-1:0]  data_in;
  logic [N-1:0]     valid_in;
  logic [N-1:0]     ready_out;
  logic [N*DW-1:0]  data_out;
  logic [N-1:0]     valid_out;
  logic [N-1:0]     ready_in;
  logic             err_drop;
  logic             err_conflict;

  int n_vec;
  int n_bad;

  bit         dlv [N][N];
  bit         m_err_drop;
  bit         m_err_conf;
  logic [N-1:0] last_rdy;

  cast_xbar_fork #(.NPORT(N), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_in       (sel_in),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .err_drop     (err_drop),
    .err_conflict (err_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: each output serves the lowest-index input still owing it a copy.
  task automatic tick();
    logic [N-1:0]    e_vout;
    logic [N-1:0]    e_rdy;
    logic [N*DW-1:0] e_data;
    bit              tk [N][N];
    bit              conf;
    bit              drop;
    int              owner;
    int              left;
    #2;
    e_vout = '0; e_rdy = '0; e_data = '0; conf = 0; drop = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) tk[i][j] = 0;
    for (int j = 0; j < N; j++) begin
      owner = -1;
      for (int i = 0; i < N; i++)
        if (valid_in[i] && sel_in[i*N+j] && !dlv[i][j]) begin
          if (owner < 0) owner = i;
          else conf = 1;
        end
      if (owner >= 0) begin
        e_vout[j] = 1'b1;
        e_data[j*DW +: DW] = data_in[owner*DW +: DW];
        tk[owner][j] = ready_in[j];
      end
    end
    for (int i = 0; i < N; i++)
      if (valid_in[i]) begin
        left = 0;
        for (int j = 0; j < N; j++)
          if (sel_in[i*N+j] && !dlv[i][j] && !tk[i][j]) left++;
        e_rdy[i] = (left == 0);
        if (sel_in[i*N +: N] == '0) drop = 1;
      end
    chk("valid_out", 64'(valid_out), 64'(e_vout));
    chk("data_out", 64'(data_out), 64'(e_data));
    chk("ready_out", 64'(ready_out), 64'(e_rdy));
    chk("err_drop", 64'(err_drop), 64'(m_err_drop));
    chk("err_conflict", 64'(err_conflict), 64'(m_err_conf));
    last_rdy = e_rdy;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) dlv[i][j] = 0;
      m_err_drop = 0;
      m_err_conf = 0;
    end else begin
      m_err_drop = m_err_drop | drop;
      m_err_conf = m_err_conf | conf;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          dlv[i][j] = e_rdy[i] ? 1'b0 : (dlv[i][j] | tk[i][j]);
    end
    #1;
  endtask

  task automatic idle_inputs();
    sel_in = '0; data_in = '0; valid_in = '0; ready_in = '0;
  endtask

  task automatic set_flit(input int i, input logic [N-1:0] sel, input logic [DW-1:0] d);
    sel_in[i*N +: N]    = sel;
    data_in[i*DW +: DW] = d;
    valid_in[i]         = 1'b1;
  endtask

  function automatic logic [N-1:0] rand_sel();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return '0;
    if (r < 8)  return N'(1) << $urandom_range(0, N-1);
    return N'($urandom);
  endfunction

  initial begin
    int retired;
    n_vec = 0; n_bad = 0;
    m_err_drop = 0; m_err_conf = 0; last_rdy = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) dlv[i][j] = 0;
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    tick();

    // unicast
    set_flit(0, 5'b00100, 8'hA5); ready_in = '1;
    #1;
    chk("uni_data", 64'(data_out[2*DW +: DW]), 64'h A5);
    chk("uni_vout", 64'(valid_out), 64'b00100);
    chk("uni_rdy0", 64'(ready_out[0]), 64'd1);
    tick();
    idle_inputs();

    // staggered multicast
    set_flit(1, 5'b10011, 8'h5B); ready_in = 5'b00001;
    #1; chk("stag_c0_rdy", 64'(ready_out[1]), 64'd0); chk("stag_c0_vout", 64'(valid_out), 64'b10011);
    tick();
    ready_in = 5'b00010;
    #1; chk("stag_c1_rdy", 64'(ready_out[1]), 64'd0); chk("stag_c1_vout", 64'(valid_out), 64'b10010);
    tick();
    ready_in = 5'b10000;
    #1; chk("stag_c2_rdy", 64'(ready_out[1]), 64'd1); chk("stag_c2_vout", 64'(valid_out), 64'b10000);
    tick();
    ready_in = '0;
    #1; chk("stag_done_clr", 64'(valid_out), 64'b10011);
    tick();
    idle_inputs();

    // conflict on out3
    set_flit(0, 5'b01000, 8'h11); set_flit(3, 5'b01000, 8'h33); ready_in = '1;
    #1; chk("conf_first", 64'(data_out[3*DW +: DW]), 64'h11); chk("conf_rdy3", 64'(ready_out[3]), 64'd0);
    tick();
    valid_in[0] = 1'b0;
    #1; chk("conf_second", 64'(data_out[3*DW +: DW]), 64'h33); chk("conf_flag", 64'(err_conflict), 64'd1);
    tick();
    idle_inputs();
    tick();
    chk("conf_sticky", 64'(err_conflict), 64'd1);

    // zero mask
    set_flit(4, 5'b00000, 8'hEE); ready_in = '1;
    #1; chk("zero_rdy4", 64'(ready_out[4]), 64'd1); chk("zero_vout", 64'(valid_out), 64'd0);
    tick();
    chk("zero_flag", 64'(err_drop), 64'd1);
    idle_inputs();

    // reset mid-fork
    set_flit(2, 5'b00110, 8'h3C); ready_in = 5'b00010;
    #1; chk("rst_part_rdy", 64'(ready_out[2]), 64'd0);
    tick();
    ready_in = '0; rst = 1'b1;
    tick();
    rst = 1'b0; ready_in = 5'b00110;
    #1;
    chk("rst_redeliver", 64'(valid_out), 64'b00110);
    chk("rst_rdy2", 64'(ready_out[2]), 64'd1);
    chk("rst_flags", 64'({err_drop, err_conflict}), 64'd0);
    tick();
    idle_inputs();

    // back-to-back multicast
    retired = 0;
    ready_in = '1;
    for (int k = 0; k < 8; k++) begin
      set_flit(0, 5'b00011, DW'(8'h10 + k));
      #1;
      chk("b2b_out0", 64'(data_out[0 +: DW]), 64'(8'h10 + k));
      chk("b2b_out1", 64'(data_out[DW +: DW]), 64'(8'h10 + k));
      if (ready_out[0] && valid_in[0]) retired++;
      tick();
    end
    chk("b2b_retired", 64'(retired), 64'd8);
    idle_inputs();

    // random traffic, inputs hold their flit until retired
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!valid_in[i] || last_rdy[i]) begin
          if ($urandom_range(0, 9) < 6) set_flit(i, rand_sel(), DW'($urandom));
          else valid_in[i] = 1'b0;
        end
      ready_in = N'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
